// File: rtl/vga_fb_arbiter.sv
// vga_fb_arbiter
//   Shares one single-port, 1-cycle-latency frame-buffer RAM between display
//   scan-out (strict priority) and a host writer (valid/ready). Scan-out reads
//   are prefetched into a small FIFO so a pixel is already at the FIFO head in
//   the cycle DISPLAY_EN consumes it.
//
// Ports
//   FCLK         pixel clock, rising edge
//   RST_IN       asynchronous active-low reset
//   FRAME_START  one-cycle pulse in vertical blanking, restarts scan-out at 0
//   DISPLAY_EN   pixel consumed this cycle (FIFO pop)
//   PIXEL_DATA   FIFO head (RGB332), 0 when the FIFO is empty
//   UNDERFLOW    sticky, set by a pop on an empty FIFO, cleared by FRAME_START
//   WR_VALID / WR_READY / WR_ADDR / WR_DATA   host write handshake
//   MEM_EN / MEM_WE / MEM_ADDR / MEM_WDATA    RAM command
//   MEM_RDATA    RAM read data, valid the cycle after a read
module vga_fb_arbiter #(
  parameter int H_VISIBLE = 1024,
  parameter int V_VISIBLE = 768,
  parameter int ADDR_W    = 20,
  parameter int DEPTH     = 4
) (
  input  logic              FCLK,
  input  logic              RST_IN,
  input  logic              FRAME_START,
  input  logic              DISPLAY_EN,
  output logic [7:0]        PIXEL_DATA,
  output logic              UNDERFLOW,
  input  logic              WR_VALID,
  output logic              WR_READY,
  input  logic [ADDR_W-1:0] WR_ADDR,
  input  logic [7:0]        WR_DATA,
  output logic              MEM_EN,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [7:0]        MEM_WDATA,
  input  logic [7:0]        MEM_RDATA
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_VISIBLE * V_VISIBLE - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(DEPTH - 1);
  localparam logic [OCC_W:0]    DEPTH_EXT = (OCC_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_done;
  logic              inflight;

  logic [7:0]        fifo_mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  occ;

  logic              fifo_empty;
  logic [OCC_W:0]    pending;
  logic              rd_issue;
  logic              push;
  logic              pop;

  // Pointer advance that also works when DEPTH is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign fifo_empty = (occ == '0);

  // Slots already spoken for: stored entries plus the read whose data
  // arrives next cycle. A pop in the current cycle is deliberately not
  // credited, which keeps the issue decision purely registered.
  assign pending = {1'b0, occ} + {{OCC_W{1'b0}}, inflight};

  // RST_IN gating keeps the RAM idle while reset is held; the first read
  // goes out in the cycle after release.
  assign rd_issue = RST_IN && !fetch_done && (pending < DEPTH_EXT) && !FRAME_START;

  // FRAME_START discards the returning read and ignores any pop.
  assign push = inflight && !FRAME_START;
  assign pop  = DISPLAY_EN && !fifo_empty && !FRAME_START;

  assign PIXEL_DATA = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];

  // Scan-out owns the RAM whenever it wants it; the host only gets the
  // leftover cycles, so WR_READY never looks at WR_VALID.
  always_comb begin
    MEM_EN    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_ADDR  = '0;
    MEM_WDATA = 8'h00;
    WR_READY  = 1'b1;
    if (rd_issue) begin
      MEM_EN   = 1'b1;
      MEM_ADDR = fetch_addr;
      WR_READY = 1'b0;
    end else if (WR_VALID && RST_IN) begin
      MEM_EN    = 1'b1;
      MEM_WE    = 1'b1;
      MEM_ADDR  = WR_ADDR;
      MEM_WDATA = WR_DATA;
    end
  end

  // The fetch address stops on the last visible pixel instead of wrapping,
  // so scan-out goes quiet until the next FRAME_START.
  always_ff @(posedge FCLK or negedge RST_IN) begin
    if (!RST_IN) begin
      fetch_addr <= '0;
      fetch_done <= 1'b0;
      inflight   <= 1'b0;
    end else if (FRAME_START) begin
      fetch_addr <= '0;
      fetch_done <= 1'b0;
      inflight   <= 1'b0;
    end else begin
      inflight <= rd_issue;
      if (rd_issue) begin
        if (fetch_addr == LAST_ADDR) begin
          fetch_done <= 1'b1;
        end else begin
          fetch_addr <= fetch_addr + ADDR_W'(1);
        end
      end
    end
  end

  always_ff @(posedge FCLK or negedge RST_IN) begin
    if (!RST_IN) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else if (FRAME_START) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_next(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_next(rd_ptr);
      end
      if (push && !pop) begin
        occ <= occ + OCC_W'(1);
      end else if (pop && !push) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end

  // Storage needs no reset: occ gates every read of it.
  always_ff @(posedge FCLK) begin
    if (push) begin
      fifo_mem[wr_ptr] <= MEM_RDATA;
    end
  end

  always_ff @(posedge FCLK or negedge RST_IN) begin
    if (!RST_IN) begin
      UNDERFLOW <= 1'b0;
    end else if (FRAME_START) begin
      UNDERFLOW <= 1'b0;
    end else if (DISPLAY_EN && fifo_empty) begin
      UNDERFLOW <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb_vga_fb_arbiter
//   Bench for vga_fb_arbiter: a full-size instance (1024x768, DEPTH 4) backed
//   by a behavioural RAM preloaded with data = addr[7:0], and a tiny 4x2
//   instance used for the end-of-frame behaviour.
module tb_vga_fb_arbiter;

  localparam int ADDR_W = 20;
  localparam int DEPTH  = 4;
  localparam int TOTAL  = 1024 * 768;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic              fs, de, wv, rdy, uf, men, mwe;
  logic [ADDR_W-1:0] wa, maddr;
  logic [7:0]        wd, pix, mwdata, mrdata;

  logic              s_fs, s_de, s_wv, s_rdy, s_uf, s_men, s_mwe;
  logic [ADDR_W-1:0] s_wa, s_maddr;
  logic [7:0]        s_wd, s_pix, s_mwdata, s_mrdata;

  vga_fb_arbiter #(.H_VISIBLE(1024), .V_VISIBLE(768), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .FCLK(clk), .RST_IN(rst_n), .FRAME_START(fs), .DISPLAY_EN(de),
    .PIXEL_DATA(pix), .UNDERFLOW(uf), .WR_VALID(wv), .WR_READY(rdy),
    .WR_ADDR(wa), .WR_DATA(wd), .MEM_EN(men), .MEM_WE(mwe),
    .MEM_ADDR(maddr), .MEM_WDATA(mwdata), .MEM_RDATA(mrdata)
  );

  vga_fb_arbiter #(.H_VISIBLE(4), .V_VISIBLE(2), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut_small (
    .FCLK(clk), .RST_IN(rst_n), .FRAME_START(s_fs), .DISPLAY_EN(s_de),
    .PIXEL_DATA(s_pix), .UNDERFLOW(s_uf), .WR_VALID(s_wv), .WR_READY(s_rdy),
    .WR_ADDR(s_wa), .WR_DATA(s_wd), .MEM_EN(s_men), .MEM_WE(s_mwe),
    .MEM_ADDR(s_maddr), .MEM_WDATA(s_mwdata), .MEM_RDATA(s_mrdata)
  );

  // Behavioural single-port RAMs with one cycle of read latency.
  logic [7:0] ram   [0:(1<<ADDR_W)-1];
  logic [7:0] s_ram [0:15];

  always @(posedge clk) begin
    if (men) begin
      if (mwe) ram[maddr] <= mwdata;
      else     mrdata <= ram[maddr];
    end
  end

  always @(posedge clk) begin
    if (s_men) begin
      if (s_mwe) s_ram[s_maddr[3:0]] <= s_mwdata;
      else       s_mrdata <= s_ram[s_maddr[3:0]];
    end
  end

  int checks = 0;
  int passes = 0;

  // Reference model of the scan-out side: a plain queue for the FIFO and
  // a one-deep "data arriving next cycle" slot.
  int              m_addr;
  bit              m_done;
  bit              m_infl;
  byte unsigned    m_infl_data;
  byte unsigned    m_q[$];
  bit              m_uf;

  typedef struct {
    bit          fs, de, wv;
    logic [19:0] wa;
    logic [7:0]  wd;
    bit          en, we;
    logic [19:0] addr;
    bit          rdy;
    logic [7:0]  pix;
    bit          uf;
  } vec_t;

  vec_t vecs[9];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input bit fs_v, input bit de_v, input bit wv_v,
                               input logic [19:0] wa_v, input logic [7:0] wd_v);
    @(negedge clk);
    fs = fs_v;
    de = de_v;
    wv = wv_v;
    wa = wa_v;
    wd = wd_v;
    #1;
  endtask

  task automatic modelReset();
    m_addr      = 0;
    m_done      = 1'b0;
    m_infl      = 1'b0;
    m_infl_data = 8'h00;
    m_q.delete();
    m_uf        = 1'b0;
  endtask

  function automatic bit expRd();
    return !m_done && (m_q.size() + int'(m_infl) < DEPTH) && !fs;
  endfunction

  task automatic modelCheck(input string tag);
    bit          rd;
    logic        e_en, e_we, e_rdy;
    logic [19:0] e_addr;
    logic [7:0]  e_wd, e_pix;
    rd     = expRd();
    e_rdy  = !rd;
    e_en   = 1'b0;
    e_we   = 1'b0;
    e_addr = '0;
    e_wd   = 8'h00;
    if (rd) begin
      e_en   = 1'b1;
      e_addr = 20'(m_addr);
    end else if (wv) begin
      e_en   = 1'b1;
      e_we   = 1'b1;
      e_addr = wa;
      e_wd   = wd;
    end
    e_pix = (m_q.size() > 0) ? m_q[0] : 8'h00;
    checkOutput({tag, ".mem_en"},   32'(men),   32'(e_en));
    checkOutput({tag, ".mem_we"},   32'(mwe),   32'(e_we));
    checkOutput({tag, ".mem_addr"}, 32'(maddr), 32'(e_addr));
    if (!rd) checkOutput({tag, ".mem_wdata"}, 32'(mwdata), 32'(e_wd));
    checkOutput({tag, ".wr_ready"}, 32'(rdy),   32'(e_rdy));
    checkOutput({tag, ".pixel"},    32'(pix),   32'(e_pix));
    checkOutput({tag, ".underflow"}, 32'(uf),   32'(m_uf));
  endtask

  // Advance the model over the coming clock edge; runs before the edge so
  // the RAM contents it reads are the ones the DUT's read will see.
  task automatic modelStep();
    bit rd;
    rd = expRd();
    if (fs) begin
      modelReset();
    end else begin
      if (de && m_q.size() == 0) m_uf = 1'b1;
      if (de && m_q.size() > 0) void'(m_q.pop_front());
      if (m_infl) m_q.push_back(m_infl_data);
      m_infl = rd;
      if (rd) begin
        m_infl_data = ram[20'(m_addr)];
        if (m_addr == TOTAL - 1) m_done = 1'b1;
        else m_addr++;
      end
    end
  endtask

  task automatic runCycle(input bit fs_v, input bit de_v, input bit wv_v,
                          input logic [19:0] wa_v, input logic [7:0] wd_v, input string tag);
    applyStimulus(fs_v, de_v, wv_v, wa_v, wd_v);
    modelCheck(tag);
    modelStep();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int ready_highs;
    int we_hits, we_cycles, xfer_at;
    bit hold_wv;
    int reads;

    // Fill and first pops after reset release, DISPLAY_EN low until vec 7.
    vecs[0] = '{1'b0,1'b0,1'b0,20'h0,8'h00, 1'b1,1'b0,20'h0,1'b0,8'h00,1'b0};
    vecs[1] = '{1'b0,1'b0,1'b0,20'h0,8'h00, 1'b1,1'b0,20'h1,1'b0,8'h00,1'b0};
    vecs[2] = '{1'b0,1'b0,1'b0,20'h0,8'h00, 1'b1,1'b0,20'h2,1'b0,8'h00,1'b0};
    vecs[3] = '{1'b0,1'b0,1'b0,20'h0,8'h00, 1'b1,1'b0,20'h3,1'b0,8'h00,1'b0};
    vecs[4] = '{1'b0,1'b0,1'b0,20'h0,8'h00, 1'b0,1'b0,20'h0,1'b1,8'h00,1'b0};
    vecs[5] = '{1'b0,1'b0,1'b0,20'h0,8'h00, 1'b0,1'b0,20'h0,1'b1,8'h00,1'b0};
    vecs[6] = '{1'b0,1'b0,1'b1,20'h12345,8'hA5, 1'b1,1'b1,20'h12345,1'b1,8'h00,1'b0};
    vecs[7] = '{1'b0,1'b1,1'b0,20'h0,8'h00, 1'b0,1'b0,20'h0,1'b1,8'h00,1'b0};
    vecs[8] = '{1'b0,1'b1,1'b0,20'h0,8'h00, 1'b1,1'b0,20'h4,1'b0,8'h01,1'b0};

    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'(i);
    for (int i = 0; i < 16; i++) s_ram[i] = 8'(8'h40 + i);

    rst_n = 1'b0;
    fs = 0; de = 0; wv = 0; wa = '0; wd = '0;
    s_fs = 0; s_de = 0; s_wv = 0; s_wa = '0; s_wd = '0;

    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst.wr_ready",  32'(rdy),    32'd1);
    checkOutput("rst.mem_en",    32'(men),    32'd0);
    checkOutput("rst.mem_we",    32'(mwe),    32'd0);
    checkOutput("rst.mem_addr",  32'(maddr),  32'd0);
    checkOutput("rst.mem_wdata", 32'(mwdata), 32'd0);
    checkOutput("rst.pixel",     32'(pix),    32'd0);
    checkOutput("rst.underflow", 32'(uf),     32'd0);

    modelReset();
    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].fs, vecs[i].de, vecs[i].wv, vecs[i].wa, vecs[i].wd);
      checkOutput($sformatf("vec%0d.mem_en", i),   32'(men),   32'(vecs[i].en));
      checkOutput($sformatf("vec%0d.mem_we", i),   32'(mwe),   32'(vecs[i].we));
      checkOutput($sformatf("vec%0d.mem_addr", i), 32'(maddr), 32'(vecs[i].addr));
      if (vecs[i].we) checkOutput($sformatf("vec%0d.mem_wdata", i), 32'(mwdata), 32'(vecs[i].wd));
      checkOutput($sformatf("vec%0d.wr_ready", i), 32'(rdy),   32'(vecs[i].rdy));
      checkOutput($sformatf("vec%0d.pixel", i),    32'(pix),   32'(vecs[i].pix));
      checkOutput($sformatf("vec%0d.underflow", i), 32'(uf),   32'(vecs[i].uf));
      modelStep();
    end

    // Sustained scan-out: pixel stream follows addr[7:0], host starved.
    ready_highs = 0;
    for (int i = 0; i < 1024; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0, '0);
      if (rdy) ready_highs++;
      modelCheck("scan");
      modelStep();
    end
    checkOutput("scan.ready_highs", 32'(ready_highs), 32'd0);
    checkOutput("scan.underflow",   32'(uf),          32'd0);

    // Host write held across a refill: it must wait for the FIFO to fill.
    hold_wv = 1'b1;
    we_hits = 0; we_cycles = 0; xfer_at = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b0, 1'b0, hold_wv, 20'h12345, 8'hA5);
      modelCheck("refill");
      if (mwe) we_cycles++;
      if (hold_wv && rdy) begin
        if (men && mwe && maddr == 20'h12345 && mwdata == 8'hA5) we_hits++;
        xfer_at = i;
      end
      modelStep();
      if (hold_wv && rdy) hold_wv = 1'b0;
    end
    checkOutput("refill.write_hits",  32'(we_hits),   32'd1);
    checkOutput("refill.we_cycles",   32'(we_cycles), 32'd1);
    checkOutput("refill.xfer_cycle",  32'(xfer_at),   32'd1);

    // Pops straight after a flush underflow and the flag sticks.
    runCycle(1'b1, 1'b0, 1'b0, '0, '0, "flush");
    for (int i = 0; i < 5; i++) runCycle(1'b0, 1'b1, 1'b0, '0, '0, "uf_pop");
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
      checkOutput($sformatf("uf_hold%0d", i), 32'(uf), 32'd1);
      modelCheck("uf_hold");
      modelStep();
    end
    runCycle(1'b1, 1'b0, 1'b0, '0, '0, "uf_fs");
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("uf_cleared", 32'(uf), 32'd0);
    modelCheck("uf_after_fs");
    modelStep();

    // FRAME_START with a read in flight, a pop and a host write together.
    runCycle(1'b0, 1'b0, 1'b0, '0, '0, "pre_fs");
    runCycle(1'b0, 1'b0, 1'b0, '0, '0, "pre_fs");
    applyStimulus(1'b1, 1'b1, 1'b1, 20'h00042, 8'h5C);
    checkOutput("fs.write_we",    32'(mwe),   32'd1);
    checkOutput("fs.write_ready", 32'(rdy),   32'd1);
    checkOutput("fs.write_addr",  32'(maddr), 32'h42);
    modelCheck("fs");
    modelStep();
    applyStimulus(1'b0, 1'b0, 1'b0, '0, '0);
    checkOutput("fs_next.pixel",     32'(pix),   32'd0);
    checkOutput("fs_next.mem_en",    32'(men),   32'd1);
    checkOutput("fs_next.mem_addr",  32'(maddr), 32'd0);
    checkOutput("fs_next.underflow", 32'(uf),    32'd0);
    modelCheck("fs_next");
    modelStep();

    // Randomised traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      runCycle($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0,
               $urandom_range(0, 2) == 0, 20'($urandom), 8'($urandom), "rand");
    end

    // Tiny 4x2 frame: exactly eight reads, then only host traffic.
    @(negedge clk);
    s_fs = 1'b1;
    #1;
    @(negedge clk);
    s_fs = 1'b0;
    s_de = 1'b1;
    reads = 0;
    for (int i = 0; i < 20; i++) begin
      #1;
      if (s_men && !s_mwe) begin
        checkOutput("small.rd_addr", 32'(s_maddr), 32'(reads));
        reads++;
      end else if (reads == 8) begin
        checkOutput("small.idle_en",  32'(s_men), 32'd0);
        checkOutput("small.idle_rdy", 32'(s_rdy), 32'd1);
      end
      @(negedge clk);
    end
    checkOutput("small.read_count", 32'(reads), 32'd8);
    checkOutput("small.underflow",  32'(s_uf),  32'd1);
    checkOutput("small.drained_pix", 32'(s_pix), 32'd0);
    s_wv = 1'b1;
    s_wa = 20'h5;
    s_wd = 8'h77;
    #1;
    checkOutput("small.wr_en",    32'(s_men),    32'd1);
    checkOutput("small.wr_we",    32'(s_mwe),    32'd1);
    checkOutput("small.wr_rdy",   32'(s_rdy),    32'd1);
    checkOutput("small.wr_wdata", 32'(s_mwdata), 32'h77);
    @(negedge clk);
    s_wv = 1'b0;
    s_de = 1'b0;
    s_fs = 1'b1;
    @(negedge clk);
    s_fs = 1'b0;
    #1;
    checkOutput("small.restart_en",   32'(s_men),   32'd1);
    checkOutput("small.restart_addr", 32'(s_maddr), 32'd0);
    checkOutput("small.restart_rdy",  32'(s_rdy),   32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
